// File: rtl/cross_bar_pkg.sv
// Shared sizes, index types and the per-slave state encoding for the crossbar arbiter matrix.
// All crossbar files import this package.
package cross_bar_pkg;

  localparam int MASTER_N = 4;
  localparam int SLAVE_N  = 4;
  localparam int MASTER_W = (MASTER_N > 1) ? $clog2(MASTER_N) : 1;
  localparam int SLAVE_W  = (SLAVE_N > 1) ? $clog2(SLAVE_N) : 1;

  typedef logic [MASTER_W-1:0] master_num_t;
  typedef logic [SLAVE_W-1:0]  slave_num_t;
  typedef logic [MASTER_N-1:0] master_vec_t;
  typedef logic [SLAVE_N-1:0]  slave_vec_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } slv_state_t;

  // Round-robin successor, wrapping MASTER_N-1 back to 0.
  function automatic master_num_t next_master(input master_num_t m);
    return (int'(m) == MASTER_N - 1) ? '0 : master_num_t'(m + 1'b1);
  endfunction

endpackage

// File: rtl/cross_bar_arb_matrix_if.sv
// Master-port / slave-side bundle of the crossbar arbiter matrix.
// The arbiter sits on the slave modport; the requesting side drives the master modport.
interface cross_bar_arb_matrix_if;
  import cross_bar_pkg::*;

  master_vec_t                 m_req;
  slave_num_t [MASTER_N-1:0]   m_addr;
  master_vec_t                 m_last;
  slave_vec_t                  s_ack;
  master_num_t [SLAVE_N-1:0]   s_sel;
  slave_vec_t                  s_vld;
  master_vec_t                 m_gnt;
  master_vec_t                 m_ack;
  master_vec_t                 m_abort;

  modport master (
    output m_req, m_addr, m_last, s_ack,
    input  s_sel, s_vld, m_gnt, m_ack, m_abort
  );

  modport slave (
    input  m_req, m_addr, m_last, s_ack,
    output s_sel, s_vld, m_gnt, m_ack, m_abort
  );

endinterface

// File: rtl/cross_bar_rr_arbiter.sv
// One slave's round-robin arbiter with transaction locking: picks the first candidate at or
// after the pointer, holds the owner until its last beat is acked or its request drops.
module cross_bar_rr_arbiter
  import cross_bar_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  master_vec_t i_cand,
  input  master_vec_t i_m_req,
  input  master_vec_t i_m_last,
  input  logic        i_ack,
  output master_num_t o_sel,
  output logic        o_vld,
  output master_vec_t o_abort
);

  slv_state_t  r_state;
  master_num_t r_ptr;
  master_num_t r_sel;
  master_vec_t r_abort;

  master_num_t w_idx;
  master_num_t w_win;
  logic        w_win_vld;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path can infer a latch.
    w_idx     = '0;
    w_win     = '0;
    w_win_vld = 1'b0;
    for (int i = 0; i < MASTER_N; i++) begin
      w_idx = master_num_t'((int'(r_ptr) + i) % MASTER_N);
      if (!w_win_vld && i_cand[w_idx]) begin
        w_win     = w_idx;
        w_win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking throughout so every register samples values from before the edge.
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_abort <= '0;
    end else begin
      r_abort <= '0;
      case (r_state)
        IDLE: begin
          if (w_win_vld) begin
            r_state <= BUSY;
            r_sel   <= w_win;
          end
        end
        BUSY: begin
          // A final acked beat wins over a dropped request: normal completion, no abort.
          if (i_ack && i_m_last[r_sel]) begin
            r_state <= IDLE;
            r_ptr   <= next_master(r_sel);
          end else if (!i_m_req[r_sel]) begin
            r_state          <= IDLE;
            r_ptr            <= next_master(r_sel);
            r_abort[r_sel]   <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_sel   = r_sel;
  assign o_vld   = (r_state == BUSY);
  assign o_abort = r_abort;

endmodule

// File: rtl/cross_bar_arb_matrix.sv
// MASTER_N x SLAVE_N crossbar arbiter matrix: decodes master requests into per-slave candidate
// vectors, runs one locking round-robin arbiter per slave, and maps ownership back to masters.
module cross_bar_arb_matrix
  import cross_bar_pkg::*;
(
  input logic                   clk,
  input logic                   rst_n,
  cross_bar_arb_matrix_if.slave bus
);

  master_vec_t w_cand  [SLAVE_N];
  master_vec_t w_abort [SLAVE_N];
  master_num_t w_sel   [SLAVE_N];
  slave_vec_t  w_vld;
  master_vec_t w_gnt;
  master_vec_t w_ack;
  master_vec_t w_abort_any;

  // Out-of-range addresses match no slave, so such a request is simply never a candidate.
  always_comb begin
    for (int s = 0; s < SLAVE_N; s++) begin
      w_cand[s] = '0;
      for (int m = 0; m < MASTER_N; m++) begin
        w_cand[s][m] = bus.m_req[m] && (bus.m_addr[m] == slave_num_t'(s)) && !w_gnt[m];
      end
    end
  end

  for (genvar s = 0; s < SLAVE_N; s++) begin : g_slave
    cross_bar_rr_arbiter u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_cand   (w_cand[s]),
      .i_m_req  (bus.m_req),
      .i_m_last (bus.m_last),
      .i_ack    (bus.s_ack[s]),
      .o_sel    (w_sel[s]),
      .o_vld    (w_vld[s]),
      .o_abort  (w_abort[s])
    );
    assign bus.s_sel[s] = w_sel[s];
  end

  // Reverse map: a master owns at most one slave, so OR-ing over slaves is unambiguous.
  always_comb begin
    w_gnt       = '0;
    w_ack       = '0;
    w_abort_any = '0;
    for (int s = 0; s < SLAVE_N; s++) begin
      w_abort_any = w_abort_any | w_abort[s];
      if (w_vld[s]) begin
        w_gnt[w_sel[s]] = 1'b1;
        if (bus.s_ack[s]) begin
          w_ack[w_sel[s]] = 1'b1;
        end
      end
    end
  end

  assign bus.s_vld   = w_vld;
  assign bus.m_gnt   = w_gnt;
  assign bus.m_ack   = w_ack;
  assign bus.m_abort = w_abort_any;

endmodule
